dwconv3x3_mac: RTL



---
 rtl/conv_pkg.sv | 19 +
 rtl/dwconv_requant.sv | 42 ++++
 rtl/dwconv3x3_mac.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// Shared types and constants for the depthwise 3x3 MAC stage.
package conv_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } dwconv_state_t;

    localparam int TAP_COUNT = 9;

    // Unsigned activation widened by one sign bit, times a signed weight.
    function automatic int prod_width(input int data_w, input int weight_w);
        return data_w + weight_w + 1;
    endfunction

    localparam int PROD_WIDTH = prod_width(8, 8);

endpackage

// File: rtl/dwconv_requant.sv
// Combinational requantizer: round-half-up, arithmetic right shift, then ReLU clamp.
module dwconv_requant #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 24
) (
    input  logic signed [ACC_WIDTH-1:0]  acc,
    input  logic        [4:0]            shift_amt,
    input  logic        [DATA_WIDTH-1:0] clamp_max,
    output logic        [DATA_WIDTH-1:0] result
);

    localparam int EXT_W = ACC_WIDTH + 1;
    localparam int PAD_W = EXT_W - DATA_WIDTH;
    localparam logic [EXT_W-1:0] ONE_EXT = {{(EXT_W-1){1'b0}}, 1'b1};

    logic signed [EXT_W-1:0] round_bias_s;
    logic signed [EXT_W-1:0] rounded_s;
    logic signed [EXT_W-1:0] shifted_s;
    logic signed [EXT_W-1:0] clamp_ext_s;

    // One extra bit of headroom keeps the rounding add from wrapping.
    always_comb begin
        round_bias_s = {EXT_W{1'b0}};
        result       = {DATA_WIDTH{1'b0}};
        if (shift_amt != 5'd0) begin
            round_bias_s = ONE_EXT << (shift_amt - 5'd1);
        end else begin
            round_bias_s = {EXT_W{1'b0}};
        end
        rounded_s   = {acc[ACC_WIDTH-1], acc} + round_bias_s;
        shifted_s   = rounded_s >>> shift_amt;
        clamp_ext_s = {{PAD_W{1'b0}}, clamp_max};
        if (shifted_s[EXT_W-1]) begin
            result = {DATA_WIDTH{1'b0}};
        end else if (shifted_s > clamp_ext_s) begin
            result = clamp_max;
        end else begin
            result = shifted_s[DATA_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/dwconv3x3_mac.sv
// Depthwise 3x3 MAC: loads one channel's kernel and bias, then streams windows
// through a 4-stage stallable pipeline to requantized 8-bit pixels.
module dwconv3x3_mac
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int WEIGHT_WIDTH = 8,
    parameter int ACC_WIDTH    = 24
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [WEIGHT_WIDTH-1:0]         weight_in,
    input  logic                            weight_valid,
    output logic                            weight_ready,
    input  logic [ACC_WIDTH-1:0]            bias_in,
    input  logic [15:0]                     frame_pixels,
    input  logic [4:0]                      shift_amt,
    input  logic [DATA_WIDTH-1:0]           clamp_max,
    input  logic                            window_valid,
    input  logic [TAP_COUNT*DATA_WIDTH-1:0] window_data,
    output logic                            window_ready,
    output logic [DATA_WIDTH-1:0]           out_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic                            frame_done
);

    localparam int PW = prod_width(DATA_WIDTH, WEIGHT_WIDTH);
    localparam int RW = PW + 2;

    dwconv_state_t state_r;
    dwconv_state_t state_next_s;

    logic        [3:0]              idx_r;
    logic signed [WEIGHT_WIDTH-1:0] w_r [TAP_COUNT];
    logic signed [ACC_WIDTH-1:0]    bias_r;
    logic        [15:0]             frame_px_r;
    logic        [15:0]             in_count_r;
    logic        [15:0]             out_count_r;

    logic adv_s;
    logic window_ready_s;
    logic accept_s;
    logic out_hs_s;
    logic in_last_s;
    logic last_out_s;
    logic zero_frame_s;
    logic load_last_s;

    logic signed [PW-1:0]        prod_s [TAP_COUNT];
    logic signed [PW-1:0]        prod_r [TAP_COUNT];
    logic signed [RW-1:0]        row_s  [3];
    logic signed [RW-1:0]        row_r  [3];
    logic signed [ACC_WIDTH-1:0] acc_s;
    logic signed [ACC_WIDTH-1:0] acc_r;
    logic        [DATA_WIDTH-1:0] requant_s;
    logic        [DATA_WIDTH-1:0] out_data_r;
    logic                         v1_r;
    logic                         v2_r;
    logic                         v3_r;
    logic                         out_valid_r;

    // Handshake and frame-boundary decode.
    always_comb begin
        adv_s          = !out_valid_r || out_ready;
        window_ready_s = (state_r == RUN) && adv_s && (in_count_r < frame_px_r);
        accept_s       = window_valid && window_ready_s;
        out_hs_s       = out_valid_r && out_ready;
        in_last_s      = ({1'b0, in_count_r} + 17'd1) == {1'b0, frame_px_r};
        load_last_s    = (state_r == LOAD) && weight_valid && (idx_r == 4'd8);
        zero_frame_s   = (state_r == RUN) && (frame_px_r == 16'd0);
        if (out_hs_s && (state_r != LOAD)) begin
            last_out_s = ({1'b0, out_count_r} + 17'd1) == {1'b0, frame_px_r};
        end else begin
            last_out_s = 1'b0;
        end
    end

    assign weight_ready = (state_r == LOAD);
    assign window_ready = window_ready_s;
    assign out_valid    = out_valid_r;
    assign out_data     = out_data_r;
    assign frame_done   = last_out_s || zero_frame_s;

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= LOAD;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; finishing the frame wins over entering DRAIN.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            LOAD: begin
                if (load_last_s) begin
                    state_next_s = RUN;
                end else begin
                    state_next_s = LOAD;
                end
            end
            RUN: begin
                if (zero_frame_s || last_out_s) begin
                    state_next_s = LOAD;
                end else if (accept_s && in_last_s) begin
                    state_next_s = DRAIN;
                end else begin
                    state_next_s = RUN;
                end
            end
            DRAIN: begin
                if (last_out_s) begin
                    state_next_s = LOAD;
                end else begin
                    state_next_s = DRAIN;
                end
            end
            default: state_next_s = LOAD;
        endcase
    end

    // Kernel storage and frame counters.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            idx_r       <= 4'd0;
            bias_r      <= {ACC_WIDTH{1'b0}};
            frame_px_r  <= 16'd0;
            in_count_r  <= 16'd0;
            out_count_r <= 16'd0;
            for (int i = 0; i < TAP_COUNT; i++) begin
                w_r[i] <= {WEIGHT_WIDTH{1'b0}};
            end
        end else if ((state_r == LOAD) && weight_valid) begin
            w_r[idx_r] <= weight_in;
            if (idx_r == 4'd8) begin
                idx_r       <= 4'd0;
                bias_r      <= bias_in;
                frame_px_r  <= frame_pixels;
                in_count_r  <= 16'd0;
                out_count_r <= 16'd0;
            end else begin
                idx_r <= idx_r + 4'd1;
            end
        end else begin
            if (accept_s) begin
                in_count_r <= in_count_r + 16'd1;
            end
            if (out_hs_s) begin
                out_count_r <= out_count_r + 16'd1;
            end
        end
    end

    // Tap products: activation zero-extended, weight sign-extended to the product width.
    always_comb begin
        for (int i = 0; i < TAP_COUNT; i++) begin
            prod_s[i] = $signed({{(PW-DATA_WIDTH){1'b0}}, window_data[i*DATA_WIDTH +: DATA_WIDTH]})
                      * $signed({{(PW-WEIGHT_WIDTH){w_r[i][WEIGHT_WIDTH-1]}}, w_r[i]});
        end
    end

    // Row sums and the bias-added total, all sign-extended before adding.
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            row_s[r] = {{2{prod_r[3*r][PW-1]}},   prod_r[3*r]}
                     + {{2{prod_r[3*r+1][PW-1]}}, prod_r[3*r+1]}
                     + {{2{prod_r[3*r+2][PW-1]}}, prod_r[3*r+2]};
        end
        acc_s = {{(ACC_WIDTH-RW){row_r[0][RW-1]}}, row_r[0]}
              + {{(ACC_WIDTH-RW){row_r[1][RW-1]}}, row_r[1]}
              + {{(ACC_WIDTH-RW){row_r[2][RW-1]}}, row_r[2]}
              + bias_r;
    end

    dwconv_requant #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
    ) u_requant (
        .acc       (acc_r),
        .shift_amt (shift_amt),
        .clamp_max (clamp_max),
        .result    (requant_s)
    );

    // Four-stage pipeline; every stage holds while the output is stalled.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            v1_r        <= 1'b0;
            v2_r        <= 1'b0;
            v3_r        <= 1'b0;
            out_valid_r <= 1'b0;
            out_data_r  <= {DATA_WIDTH{1'b0}};
            acc_r       <= {ACC_WIDTH{1'b0}};
            for (int i = 0; i < TAP_COUNT; i++) begin
                prod_r[i] <= {PW{1'b0}};
            end
            for (int r = 0; r < 3; r++) begin
                row_r[r] <= {RW{1'b0}};
            end
        end else if (adv_s) begin
            v1_r        <= accept_s;
            v2_r        <= v1_r;
            v3_r        <= v2_r;
            out_valid_r <= v3_r;
            if (accept_s) begin
                for (int i = 0; i < TAP_COUNT; i++) begin
                    prod_r[i] <= prod_s[i];
                end
            end
            for (int r = 0; r < 3; r++) begin
                row_r[r] <= row_s[r];
            end
            acc_r <= acc_s;
            if (v3_r) begin
                out_data_r <= requant_s;
            end
        end
    end

endmodule
